// File: rtl/regfile_pkg.sv
// Shared types and defaults for the multi-port register file.
// The clear-sequencer state encoding lives here so the top and the sequencer agree on it.
package regfile_pkg;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_NUM_REGS = 32;
  localparam int DEF_NUM_RD   = 2;
  localparam int DEF_NUM_WR   = 1;
  localparam int DEF_ZERO_REG = 1;
  localparam int DEF_BYPASS   = 1;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

  // Low bit of port 'port' inside a flat bus made of 'width'-bit slices.
  function automatic int slice_lo(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/regfile_clear_seq.sv
// Clear sequencer: walks an index over every register, one per cycle, after a clr_req pulse.
// While the sweep runs the top level blocks external writes and read bypass.
module regfile_clear_seq
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int AW       = $clog2(DEF_NUM_REGS)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clr_req,
  output logic          clr_busy,
  output logic          clr_we,
  output logic [AW-1:0] clr_idx
);

  localparam logic [0:0]    IDLE     = ST_IDLE;
  localparam logic [0:0]    CLEAR    = ST_CLEAR;
  localparam logic [AW-1:0] LAST_IDX = AW'(NUM_REGS - 1);

  logic [0:0]    state_reg;
  logic [0:0]    state_next;
  logic [AW-1:0] idx_reg;
  logic [AW-1:0] idx_next;

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    case (state_reg)
      IDLE: begin
        if (clr_req) begin
          state_next = CLEAR;
          idx_next   = '0;
        end
      end
      CLEAR: begin
        // clr_req is deliberately not looked at here: a re-request mid-sweep is ignored.
        if (idx_reg == LAST_IDX) begin
          state_next = IDLE;
          idx_next   = '0;
        end else begin
          idx_next = idx_reg + AW'(1);
        end
      end
      default: begin
        state_next = IDLE;
        idx_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
    end
  end

  assign clr_busy = (state_reg == CLEAR);
  assign clr_we   = (state_reg == CLEAR);
  assign clr_idx  = idx_reg;

endmodule

// File: rtl/register_file_mp.sv
// Parametrised multi-port register file with registered reads, write-port priority,
// optional same-cycle write-to-read bypass and a hardware clear sweep.
module register_file_mp
  import regfile_pkg::*;
#(
  parameter int  DATA_W   = DEF_DATA_W,
  parameter int  NUM_REGS = DEF_NUM_REGS,
  parameter int  NUM_RD   = DEF_NUM_RD,
  parameter int  NUM_WR   = DEF_NUM_WR,
  parameter int  ZERO_REG = DEF_ZERO_REG,
  parameter int  BYPASS   = DEF_BYPASS,
  localparam int AW       = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_RD*AW-1:0]     rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*AW-1:0]     wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic                     clr_req,
  output logic                     clr_busy
);

  logic          clr_we;
  logic [AW-1:0] clr_idx;

  regfile_clear_seq #(
    .NUM_REGS (NUM_REGS),
    .AW       (AW)
  ) u_clear_seq (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .clr_we   (clr_we),
    .clr_idx  (clr_idx)
  );

  // Current contents of every register, as seen by the read ports.
  logic [DATA_W-1:0] mem_rd [NUM_REGS];

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    if (ZERO_REG != 0 && gi == 0) begin : g_zero
      assign mem_rd[gi] = '0;
    end else begin : g_store
      logic              we;
      logic [DATA_W-1:0] wdata;
      logic [DATA_W-1:0] q_reg;

      // Ascending scan so the highest-indexed matching port wins.
      always_comb begin
        we    = 1'b0;
        wdata = '0;
        if (clr_busy) begin
          we = clr_we && (clr_idx == AW'(gi));
        end else begin
          for (int p = 0; p < NUM_WR; p++) begin
            if (wr_en[p] && (wr_addr[slice_lo(p, AW) +: AW] == AW'(gi))) begin
              we    = 1'b1;
              wdata = wr_data[slice_lo(p, DATA_W) +: DATA_W];
            end
          end
        end
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          q_reg <= '0;
        end else if (we) begin
          q_reg <= wdata;
        end
      end

      assign mem_rd[gi] = q_reg;
    end
  end

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    logic [AW-1:0]     addr;
    logic [DATA_W-1:0] rd_next;
    logic [DATA_W-1:0] rd_data_reg;

    assign addr = rd_addr[slice_lo(gi, AW) +: AW];

    // Out-of-range and zero-register reads return 0 before bypass is considered.
    always_comb begin
      rd_next = '0;
      if ((int'(addr) < NUM_REGS) && !(ZERO_REG != 0 && addr == '0)) begin
        rd_next = mem_rd[addr];
        if (BYPASS != 0 && !clr_busy) begin
          for (int p = 0; p < NUM_WR; p++) begin
            if (wr_en[p] && (wr_addr[slice_lo(p, AW) +: AW] == addr)) begin
              rd_next = wr_data[slice_lo(p, DATA_W) +: DATA_W];
            end
          end
        end
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        rd_data_reg <= '0;
      end else begin
        rd_data_reg <= rd_next;
      end
    end

    assign rd_data[slice_lo(gi, DATA_W) +: DATA_W] = rd_data_reg;
  end

endmodule

// File: tb/tb_register_file_mp.sv
// Directed bench for register_file_mp: three configurations driven side by side,
// expected read/busy values queued at stimulus time and checked after each edge.
module tb_register_file_mp;

  logic clk;
  logic reset_n;

  // Unit A: 32x32, 2 read, 2 write, zero reg, bypass
  logic [9:0]  rd_addr_a;
  logic [63:0] rd_data_a;
  logic [1:0]  wr_en_a;
  logic [9:0]  wr_addr_a;
  logic [63:0] wr_data_a;
  logic        clr_req_a;
  logic        clr_busy_a;

  // Unit B: 32x32, 2 read, 1 write, zero reg, no bypass
  logic [9:0]  rd_addr_b;
  logic [63:0] rd_data_b;
  logic [0:0]  wr_en_b;
  logic [4:0]  wr_addr_b;
  logic [31:0] wr_data_b;
  logic        clr_req_b;
  logic        clr_busy_b;

  // Unit C: 24x16, 2 read, 1 write, zero reg, bypass
  logic [9:0]  rd_addr_c;
  logic [31:0] rd_data_c;
  logic [0:0]  wr_en_c;
  logic [4:0]  wr_addr_c;
  logic [15:0] wr_data_c;
  logic        clr_req_c;
  logic        clr_busy_c;

  register_file_mp #(
    .DATA_W(32), .NUM_REGS(32), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1), .BYPASS(1)
  ) dut_a (
    .clk(clk), .reset_n(reset_n), .rd_addr(rd_addr_a), .rd_data(rd_data_a),
    .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a),
    .clr_req(clr_req_a), .clr_busy(clr_busy_a)
  );

  register_file_mp #(
    .DATA_W(32), .NUM_REGS(32), .NUM_RD(2), .NUM_WR(1), .ZERO_REG(1), .BYPASS(0)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
    .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
    .clr_req(clr_req_b), .clr_busy(clr_busy_b)
  );

  register_file_mp #(
    .DATA_W(16), .NUM_REGS(24), .NUM_RD(2), .NUM_WR(1), .ZERO_REG(1), .BYPASS(1)
  ) dut_c (
    .clk(clk), .reset_n(reset_n), .rd_addr(rd_addr_c), .rd_data(rd_data_c),
    .wr_en(wr_en_c), .wr_addr(wr_addr_c), .wr_data(wr_data_c),
    .clr_req(clr_req_c), .clr_busy(clr_busy_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int          unit;
    int          port;   // -1 selects clr_busy
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [31:0] observe(input int unit, input int port);
    case (unit)
      0:       return (port < 0) ? {31'b0, clr_busy_a} : rd_data_a[port*32 +: 32];
      1:       return (port < 0) ? {31'b0, clr_busy_b} : rd_data_b[port*32 +: 32];
      default: return (port < 0) ? {31'b0, clr_busy_c} : {16'b0, rd_data_c[port*16 +: 16]};
    endcase
  endfunction

  task automatic expect_val(input string tag, input int unit, input int port, input logic [31:0] v);
    exp_t e;
    e.tag  = tag;
    e.unit = unit;
    e.port = port;
    e.exp  = v;
    sb.push_back(e);
  endtask

  task automatic check_pending();
    exp_t        e;
    logic [31:0] o;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = observe(e.unit, e.port);
      checks++;
      assert (o === e.exp) else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", e.tag, o, e.exp);
      end
      $display("check %s unit=%0d port=%0d observed=%h expected=%h", e.tag, e.unit, e.port, o, e.exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    check_pending();
  endtask

  function automatic logic [31:0] fill(input int r);
    return 32'hA500_0000 | 32'(r);
  endfunction

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n   = 1'b1;
    rd_addr_a = '0; wr_en_a = '0; wr_addr_a = '0; wr_data_a = '0; clr_req_a = 1'b0;
    rd_addr_b = '0; wr_en_b = '0; wr_addr_b = '0; wr_data_b = '0; clr_req_b = 1'b0;
    rd_addr_c = '0; wr_en_c = '0; wr_addr_c = '0; wr_data_c = '0; clr_req_c = 1'b0;

    // Reset state
    #1 reset_n = 1'b0;
    #1;
    expect_val("reset_a_rd0", 0, 0, 32'h0);
    expect_val("reset_a_rd1", 0, 1, 32'h0);
    expect_val("reset_a_busy", 0, -1, 32'h0);
    expect_val("reset_b_rd0", 1, 0, 32'h0);
    expect_val("reset_c_rd0", 2, 0, 32'h0);
    check_pending();
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Write reg5 on port 0, read it on port 1 next cycle
    wr_en_a = 2'b01; wr_addr_a[4:0] = 5'd5; wr_data_a[31:0] = 32'hDEADBEEF;
    tick();
    wr_en_a = 2'b00; rd_addr_a[9:5] = 5'd5;
    expect_val("wr_then_rd", 0, 1, 32'hDEADBEEF);
    tick();

    // Same-cycle write/read: bypass vs. no bypass
    wr_en_a = 2'b01; wr_addr_a[4:0] = 5'd7; wr_data_a[31:0] = 32'h1234; rd_addr_a[4:0] = 5'd7;
    wr_en_b = 1'b1;  wr_addr_b = 5'd7; wr_data_b = 32'h1234; rd_addr_b[4:0] = 5'd7;
    expect_val("bypass_on", 0, 0, 32'h1234);
    expect_val("bypass_off", 1, 0, 32'h0);
    tick();
    wr_en_a = 2'b00; wr_en_b = 1'b0;
    expect_val("nobypass_next", 1, 0, 32'h1234);
    expect_val("bypass_stored", 0, 0, 32'h1234);
    tick();

    // Two ports to the same register: port 1 wins (also through bypass)
    wr_en_a = 2'b11; wr_addr_a = {5'd3, 5'd3}; wr_data_a = {32'h5555, 32'hAAAA};
    rd_addr_a = {5'd3, 5'd0};
    expect_val("prio_bypass", 0, 1, 32'h5555);
    expect_val("zero_read", 0, 0, 32'h0);
    tick();
    wr_en_a = 2'b11; wr_addr_a = {5'd0, 5'd0}; wr_data_a = {32'hFFFF_FFFF, 32'hFFFF_FFFF};
    rd_addr_a = {5'd0, 5'd3};
    expect_val("prio_stored", 0, 0, 32'h5555);
    expect_val("zero_bypass", 0, 1, 32'h0);
    tick();
    wr_en_a = 2'b00; rd_addr_a = {5'd3, 5'd0};
    expect_val("zero_after_wr", 0, 0, 32'h0);
    expect_val("prio_port1", 0, 1, 32'h5555);
    tick();

    // Fill all registers, then sweep
    for (int r = 1; r < 32; r++) begin
      wr_en_a = 2'b01; wr_addr_a[4:0] = 5'(r); wr_data_a[31:0] = fill(r);
      tick();
    end
    wr_en_a = 2'b00;
    clr_req_a = 1'b1;
    expect_val("busy_at_T", 0, -1, 32'h1);
    tick();
    for (int j = 1; j <= 32; j++) begin
      rd_addr_a[4:0] = 5'(j - 1);
      rd_addr_a[9:5] = (j >= 2) ? 5'(j - 2) : 5'd0;
      clr_req_a      = (j == 2);
      wr_en_a        = (j == 3) ? 2'b01 : 2'b00;
      wr_addr_a[4:0] = 5'd1;
      wr_data_a[31:0] = 32'h0000_0BAD;
      expect_val("sweep_old", 0, 0, (j == 1) ? 32'h0 : fill(j - 1));
      expect_val("sweep_zeroed", 0, 1, 32'h0);
      expect_val("sweep_busy", 0, -1, (j < 32) ? 32'h1 : 32'h0);
      tick();
    end
    clr_req_a = 1'b0;
    wr_en_a = 2'b01; wr_addr_a[4:0] = 5'd4; wr_data_a[31:0] = 32'h44;
    rd_addr_a = {5'd31, 5'd1};
    expect_val("dropped_wr", 0, 0, 32'h0);
    expect_val("last_cleared", 0, 1, 32'h0);
    tick();
    wr_en_a = 2'b00; rd_addr_a[4:0] = 5'd4;
    expect_val("first_wr_after", 0, 0, 32'h44);
    tick();

    // Non-power-of-two depth: out-of-range writes and reads
    wr_en_c = 1'b1; wr_addr_c = 5'd30; wr_data_c = 16'hBEEF; rd_addr_c[4:0] = 5'd30;
    expect_val("oor_bypass", 2, 0, 32'h0);
    tick();
    wr_addr_c = 5'd23; wr_data_c = 16'h2323;
    expect_val("oor_read", 2, 0, 32'h0);
    tick();
    wr_en_c = 1'b0; rd_addr_c = {5'd23, 5'd22};
    expect_val("unwritten_22", 2, 0, 32'h0);
    expect_val("last_reg_23", 2, 1, 32'h2323);
    tick();

    // Asynchronous reset in the middle of a sweep
    wr_en_a = 2'b01; wr_addr_a[4:0] = 5'd20; wr_data_a[31:0] = 32'h2020_2020;
    tick();
    wr_en_a = 2'b00; clr_req_a = 1'b1; rd_addr_a[4:0] = 5'd20;
    expect_val("rst_sweep_busy", 0, -1, 32'h1);
    tick();
    clr_req_a = 1'b0;
    expect_val("rst_pre_val", 0, 0, 32'h2020_2020);
    tick();
    expect_val("rst_pre_val2", 0, 0, 32'h2020_2020);
    expect_val("rst_pre_busy", 0, -1, 32'h1);
    tick();
    #2 reset_n = 1'b0;
    #1;
    expect_val("async_busy", 0, -1, 32'h0);
    expect_val("async_rd0", 0, 0, 32'h0);
    expect_val("async_rd_c", 2, 1, 32'h0);
    check_pending();
    reset_n = 1'b1;
    rd_addr_a = {5'd4, 5'd20};
    expect_val("post_rst_20", 0, 0, 32'h0);
    expect_val("post_rst_4", 0, 1, 32'h0);
    expect_val("post_rst_c23", 2, 1, 32'h0);
    expect_val("post_rst_busy", 0, -1, 32'h0);
    tick();
    wr_en_a = 2'b10; wr_addr_a[9:5] = 5'd12; wr_data_a[63:32] = 32'h1212;
    rd_addr_a[4:0] = 5'd12;
    expect_val("post_rst_bypass", 0, 0, 32'h1212);
    tick();
    wr_en_a = 2'b00;
    expect_val("post_rst_stored", 0, 0, 32'h1212);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/register_file_mp.md
# register_file_mp

Parametrised multi-port register file. It is the next generation of the single-cycle CPU's 32×32 register file, with configurable width, depth and port counts, and with write-port priority, an optional same-cycle write-to-read bypass and a hardware clear sequencer. It sits between decode (read addresses) and writeback (write ports). Read data is registered, giving one cycle of latency, so it is drop-in compatible with the existing datapath timing.

## Interface
- DATA_W, 32, bits per register
- NUM_REGS, 32, register count (≥2); AW = $clog2(NUM_REGS)
- NUM_RD, 2, read ports (≥1)
- NUM_WR, 1, write ports (≥1)
- ZERO_REG, 1, 1 = register 0 hardwired to zero; writes to it are dropped
- BYPASS, 1, 1 = same-cycle write data is forwarded to a registered read of the same address

- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- rd_addr  in  NUM_RD*AW  read addresses; port k occupies bits [k*AW +: AW]
- rd_data  out  NUM_RD*DATA_W  registered read data; port k occupies bits [k*DATA_W +: DATA_W]
- wr_en  in  NUM_WR  per-port write enable
- wr_addr  in  NUM_WR*AW  write addresses
- wr_data  in  NUM_WR*DATA_W  write data
- clr_req  in  1  single-cycle pulse that starts a clear sweep
- clr_busy  out  1  high while a clear sweep is running

## Operation
- **Reset** (reset_n low, asynchronous):
  - all registers = 0, rd_data = 0, clr_busy = 0, FSM = IDLE, sweep index = 0.
  - Reset asserted mid-sweep aborts the sweep immediately.
- **Reads:** at each edge, rd_data[k] loads the contents of the register at rd_addr[k].
  - Returns 0 if the address ≥ NUM_REGS.
  - Returns 0 if ZERO_REG=1 and the address is 0.
- **Bypass** (BYPASS=1, FSM IDLE): if any enabled write port targets rd_addr[k] in the same cycle, rd_data[k] loads the winning write data instead of the stored value.
  - Zero-register and out-of-range rules still take precedence.
- **Writes:** at each edge, each port with wr_en set writes wr_data to wr_addr.
  - Dropped if the address ≥ NUM_REGS.
  - Dropped if ZERO_REG=1 and the address is 0.
  - Dropped while clr_busy=1.
  - If several ports target the same address, the highest port index wins.
- **Clear FSM**, states IDLE and CLEAR:
  - IDLE→CLEAR on clr_req=1; the sweep index is set to 0.
  - In CLEAR, register[idx] is written to 0 every cycle and idx increments.
  - CLEAR→IDLE after the cycle in which idx = NUM_REGS-1.
  - clr_req while in CLEAR is ignored.
  - Reads remain serviced during CLEAR and return the current array contents, with no bypass.
- **Widths:** all address compares use the full AW bits. When NUM_REGS is not a power of two, out-of-range addresses follow the rules above.

## Timing
- Read latency is 1 cycle: an address presented before edge N appears on rd_data after edge N.
- Write then read, BYPASS=0: a write at edge N is visible to a read sampled at edge N+1.
- Write then read, BYPASS=1: a read sampled at edge N also sees the write that lands at edge N.
- Clear sweep, with clr_req sampled at edge T:
  - clr_busy is high after edge T.
  - Register i is zeroed at edge T+1+i.
  - clr_busy is low after edge T+NUM_REGS.
- The first accepted external write is at edge T+NUM_REGS+1.
- No combinational path from any input to any output.

## Structure
- Package regfile_pkg holds:
  - the FSM state enum (IDLE, CLEAR);
  - a helper function that extracts port slices;
  - the default parameter constants.
- One sub-module, regfile_clear_seq, holds the FSM and sweep counter. Its outputs are clr_busy, clr_we and clr_idx.
- The array, write arbitration and read/bypass muxing live in the top level.

## Test plan
- Reset, then write 0xDEADBEEF to reg 5 with port 0; read reg 5 on port 1 the next cycle → 0xDEADBEEF after one edge.
- BYPASS=1: write 0x1234 to reg 7 and read reg 7 in the same cycle → rd_data = 0x1234 after that edge. With BYPASS=0 the same stimulus returns the old value (0).
- NUM_WR=2: ports 0 and 1 both write reg 3, with 0xAAAA and 0x5555 → reg 3 reads 0x5555. A write to reg 0 reads back 0.
- Fill all registers, pulse clr_req at edge T:
  - clr_busy is high for exactly NUM_REGS cycles;
  - reg i reads 0 from edge T+1+i onward;
  - a write issued at T+3 is dropped;
  - a second clr_req at T+2 is ignored.
- Drop reset_n asynchronously mid-sweep and mid-cycle → clr_busy and rd_data go to 0 immediately; after release, the FSM is IDLE and all registers read 0.
- NUM_REGS=24, DATA_W=16: a write to address 30 is dropped and a read of address 30 returns 0. A read of address 23 returns its last written value.
